rggen_backdoor_arbiter: RTL

- Multi-channel, parametrised successor to the single-path backdoor hook: N testbench-side backdoor agents issue read or masked-write requests to one register field's value.
- Arbitrates between channels, serialises each access against frontdoor (bus) activity, and returns read data plus an error status per request.
- Sits between the backdoor interface instances and the field's value/update logic; synthesised only under the backdoor-enable define.

---
 rtl/rggen_backdoor_arbiter.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/rggen_backdoor_arbiter.sv
// Backdoor access arbiter: N backdoor channels share one register field.
// A granted request waits for the frontdoor to go idle, is applied to the
// field for exactly one cycle, and is answered with the pre-access value.
// A request that waits TIMEOUT cycles is answered with an error and no access.
module rggen_backdoor_arbiter #(
    parameter int CHANNELS    = 2,
    parameter int WIDTH       = 32,
    parameter int ROUND_ROBIN = 1,
    parameter int TIMEOUT     = 16
) (
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    input  logic [CHANNELS-1:0]       i_req_valid,
    input  logic [CHANNELS-1:0]       i_req_write,
    input  logic [CHANNELS*WIDTH-1:0] i_req_mask,
    input  logic [CHANNELS*WIDTH-1:0] i_req_data,
    output logic [CHANNELS-1:0]       o_req_ready,
    output logic [WIDTH-1:0]          o_resp_data,
    output logic                      o_resp_error,
    input  logic                      i_frontdoor_busy,
    input  logic [WIDTH-1:0]          i_value,
    output logic                      o_backdoor_valid,
    output logic                      o_backdoor_write,
    output logic [WIDTH-1:0]          o_backdoor_mask,
    output logic [WIDTH-1:0]          o_backdoor_data
);
    localparam int PTR_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    typedef enum logic [1:0] {IDLE, WAIT, ACCESS, RESP} state_e;

    state_e             state_q, state_d;
    logic [PTR_W-1:0]   ptr_q, ptr_d;
    logic [PTR_W-1:0]   grant_q, grant_d;
    logic               write_q, write_d;
    logic [WIDTH-1:0]   mask_q, mask_d;
    logic [WIDTH-1:0]   data_q, data_d;
    logic [WIDTH-1:0]   resp_q, resp_d;
    logic               err_q, err_d;
    logic [7:0]         cnt_q, cnt_d;

    logic [PTR_W-1:0]   pick;
    logic [PTR_W-1:0]   idx;

    // Channel selection: scan offsets from the far end so the nearest
    // requester (upward from the pointer, or lowest index) wins last.
    always_comb begin
        pick = '0;
        idx  = '0;
        for (int i = CHANNELS - 1; i >= 0; i--) begin
            if (ROUND_ROBIN != 0) begin
                idx = PTR_W'((int'(ptr_q) + i) % CHANNELS);
            end else begin
                idx = PTR_W'(i);
            end
            if (i_req_valid[idx]) begin
                pick = idx;
            end
        end
    end

    // State and request/response registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            grant_q <= '0;
            write_q <= 1'b0;
            mask_q  <= '0;
            data_q  <= '0;
            resp_q  <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            grant_q <= grant_d;
            write_q <= write_d;
            mask_q  <= mask_d;
            data_q  <= data_d;
            resp_q  <= resp_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state: latch the winner, wait out the frontdoor, capture, answer.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        grant_d = grant_q;
        write_d = write_q;
        mask_d  = mask_q;
        data_d  = data_q;
        resp_d  = resp_q;
        err_d   = err_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (|i_req_valid) begin
                    grant_d = pick;
                    write_d = i_req_write[pick];
                    mask_d  = i_req_mask[int'(pick)*WIDTH +: WIDTH];
                    data_d  = i_req_data[int'(pick)*WIDTH +: WIDTH];
                    resp_d  = '0;
                    err_d   = 1'b0;
                    cnt_d   = '0;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (!i_frontdoor_busy) begin
                    state_d = ACCESS;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                    if (cnt_d == 8'(TIMEOUT)) begin
                        err_d   = 1'b1;
                        state_d = RESP;
                    end
                end
            end
            ACCESS: begin
                // Pre-write value: the field updates on this same edge.
                resp_d  = i_value;
                state_d = RESP;
            end
            RESP: begin
                ptr_d   = (CHANNELS > 1) ? PTR_W'((int'(grant_q) + 1) % CHANNELS) : '0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs are pure functions of state, so reset clears them immediately.
    always_comb begin
        o_req_ready      = '0;
        o_resp_data      = '0;
        o_resp_error     = 1'b0;
        o_backdoor_valid = 1'b0;
        o_backdoor_write = 1'b0;
        o_backdoor_mask  = '0;
        o_backdoor_data  = '0;
        case (state_q)
            ACCESS: begin
                o_backdoor_valid = 1'b1;
                o_backdoor_write = write_q;
                o_backdoor_mask  = write_q ? mask_q : '0;
                o_backdoor_data  = data_q;
            end
            RESP: begin
                o_req_ready[grant_q] = 1'b1;
                o_resp_error         = err_q;
                o_resp_data          = err_q ? '0 : resp_q;
            end
            default: ;
        endcase
    end

endmodule
